// File: rtl/sha256_pkg.sv
// SHA-256 compression shared constants: IV, round constants,
// FSM state type and the big-sigma / choose / majority helpers.
package sha256_pkg;

  localparam int ROUNDS      = 64;
  localparam int CHUNK_WORDS = 16;

  typedef enum logic [1:0] {
    LOAD,
    ROUND,
    FINAL
  } state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[1:0], x[31:2]}
         ^ {x[12:0], x[31:13]}
         ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[5:0], x[31:6]}
         ^ {x[10:0], x[31:11]}
         ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(
    input logic [31:0] x, y, z
  );
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(
    input logic [31:0] x, y, z
  );
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Round-constant lookup: 6-bit round index to 32-bit K.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  assign k = K[idx];

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: counts 16 loaded words, runs 64 rounds
// while the schedule expands, then folds the working set into H.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init_i,
  input  logic         dat_valid_i,
  input  logic [31:0]  w_i,
  output logic         proc_ninit_o,
  output logic         ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [255:0] digest_o
);

  localparam logic [3:0] LAST_WORD  = 4'(CHUNK_WORDS - 1);
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_t       state;
  logic [3:0]   word_cnt;
  logic [5:0]   t;
  logic [255:0] hs;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  k_t, t1, t2;

  sha256_k_rom u_k_rom (
    .idx (t),
    .k   (k_t)
  );

  assign t1 = h + sig1(e) + ch(e, f, g) + k_t + w_i;
  assign t2 = sig0(a) + maj(a, b, c);

  // Round 63 consumes W63 without asking the schedule for W64.
  assign proc_ninit_o = (state == ROUND) && (t != LAST_ROUND);
  assign ready_o      = (state == LOAD);
  assign busy_o       = !ready_o;
  assign digest_o     = hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      word_cnt <= '0;
      t        <= '0;
      hs       <= IV;
      {a, b, c, d, e, f, g, h} <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (init_i) begin
        state    <= LOAD;
        hs       <= IV;
        t        <= '0;
        word_cnt <= (state == LOAD && dat_valid_i) ? 4'd1 : 4'd0;
      end else begin
        unique case (state)
          LOAD: begin
            if (dat_valid_i) begin
              if (word_cnt == LAST_WORD) begin
                word_cnt <= '0;
                t        <= '0;
                {a, b, c, d, e, f, g, h} <= hs;
                state    <= ROUND;
              end else begin
                word_cnt <= word_cnt + 4'd1;
              end
            end
          end
          ROUND: begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
            t <= t + 6'd1;
            if (t == LAST_ROUND) state <= FINAL;
          end
          FINAL: begin
            hs <= {hs[255:224] + a, hs[223:192] + b,
                   hs[191:160] + c, hs[159:128] + d,
                   hs[127:96]  + e, hs[95:64]   + f,
                   hs[63:32]   + g, hs[31:0]    + h};
            done_o <= 1'b1;
            state  <= LOAD;
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Bench for sha256_compress paired with a behavioural message
// schedule; known-answer digests plus init/reset corner cases.
module tb_sha256_compress;

  localparam logic [255:0] IV_EXP =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_EXP =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_EXP =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_EXP =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct packed {
    logic [1:0]    nchunks;
    logic          gaps;
    logic          init_first;
    logic [1023:0] words;
    logic [255:0]  exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init = 1'b0;
  logic         dat_valid = 1'b0;
  logic [31:0]  dat = '0;
  logic [31:0]  w_out;
  logic         proc_ninit, ready, busy, done;
  logic [255:0] digest;
  logic [31:0]  sched [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sha256_compress dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_i       (init),
    .dat_valid_i  (dat_valid),
    .w_i          (w_out),
    .proc_ninit_o (proc_ninit),
    .ready_o      (ready),
    .busy_o       (busy),
    .done_o       (done),
    .digest_o     (digest)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Message schedule: 16-word shift register, oldest word at sched[0].
  always @(posedge clk) begin
    if (proc_ninit) begin
      for (int i = 0; i < 15; i++) sched[i] <= sched[i+1];
      sched[15] <= ssig1(sched[14]) + sched[9] + ssig0(sched[1]) + sched[0];
    end else if (dat_valid) begin
      for (int i = 0; i < 15; i++) sched[i] <= sched[i+1];
      sched[15] <= bswap(dat);
    end
  end
  assign w_out = sched[0];

  task automatic check(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (dat_valid) begin
      n_cmp++;
      if (!ready) begin
        n_bad++;
        $display("FAIL protocol: dat_valid with ready=%b", ready);
      end
    end
  end

  task automatic pulse_init();
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Returns at the negedge of cycle 1 after the edge accepting word 15.
  task automatic send_chunk(input logic [511:0] blk, input bit gaps,
                            input bit with_init);
    for (int k = 0; k < 16; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      dat_valid = 1'b1;
      dat       = blk[k*32 +: 32];
      init      = with_init && (k == 0);
      @(negedge clk);
      init      = 1'b0;
      dat_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int lat, output int ninit, output int rdy);
    lat = 1;
    ninit = 0;
    rdy = 0;
    while (!done && lat < 100) begin
      ninit += int'(proc_ninit);
      rdy += int'(ready);
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t         vecs [3];
  logic [511:0] abc_blk, empty_blk;
  logic [7:0]   ch0;
  int           lat, ni, rd, dn;

  initial begin
    abc_blk = '0;
    abc_blk[31:0] = 32'h80636261;
    abc_blk[511:480] = 32'h18000000;
    empty_blk = '0;
    empty_blk[31:0] = 32'h00000080;

    vecs[0] = '0;
    vecs[0].nchunks = 2'd1;
    vecs[0].words[511:0] = abc_blk;
    vecs[0].exp = ABC_EXP;

    vecs[1] = '0;
    vecs[1].nchunks = 2'd1;
    vecs[1].init_first = 1'b1;
    vecs[1].words[511:0] = empty_blk;
    vecs[1].exp = EMPTY_EXP;

    vecs[2] = '0;
    vecs[2].nchunks = 2'd2;
    vecs[2].gaps = 1'b1;
    for (int i = 0; i < 14; i++) begin
      ch0 = 8'(8'h61 + i);
      vecs[2].words[i*32 +: 32] = {ch0 + 8'd3, ch0 + 8'd2, ch0 + 8'd1, ch0};
    end
    vecs[2].words[14*32 +: 32] = 32'h00000080;
    vecs[2].words[31*32 +: 32] = 32'hc0010000;
    vecs[2].exp = TWO_EXP;

    repeat (2) @(negedge clk);
    check("rst digest", digest, IV_EXP);
    check("rst done", 256'(done), 256'd0);
    check("rst busy", 256'(busy), 256'd0);
    check("rst ready", 256'(ready), 256'd1);
    check("rst ninit", 256'(proc_ninit), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      if (!vecs[v].init_first) pulse_init();
      for (int c = 0; c < int'(vecs[v].nchunks); c++) begin
        send_chunk(vecs[v].words[c*512 +: 512], vecs[v].gaps,
                   vecs[v].init_first && c == 0);
        wait_done(lat, ni, rd);
        check("done latency", 256'(lat), 256'd66);
        check("ninit count", 256'(ni), 256'd63);
        check("ready while busy", 256'(rd), 256'd0);
        check("ready at done", 256'(ready), 256'd1);
      end
      check("digest", digest, vecs[v].exp);
      @(negedge clk);
      check("done one-shot", 256'(done), 256'd0);
      check("digest held", digest, vecs[v].exp);
    end

    // init at round 30 of a second chunk must discard the chaining value
    pulse_init();
    send_chunk(abc_blk, 1'b0, 1'b0);
    wait_done(lat, ni, rd);
    check("pre-abort digest", digest, ABC_EXP);
    send_chunk(empty_blk, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    check("ninit at r30", 256'(proc_ninit), 256'd1);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("abort ninit", 256'(proc_ninit), 256'd0);
    check("abort busy", 256'(busy), 256'd0);
    check("abort ready", 256'(ready), 256'd1);
    check("abort digest", digest, IV_EXP);
    dn = 0;
    repeat (80) begin
      dn += int'(done);
      @(negedge clk);
    end
    check("abort no done", 256'(dn), 256'd0);
    send_chunk(abc_blk, 1'b0, 1'b0);
    wait_done(lat, ni, rd);
    check("post-abort latency", 256'(lat), 256'd66);
    check("post-abort digest", digest, ABC_EXP);

    // asynchronous reset while in FINAL
    @(negedge clk);
    pulse_init();
    send_chunk(abc_blk, 1'b0, 1'b0);
    repeat (64) @(negedge clk);
    check("final busy", 256'(busy), 256'd1);
    check("final ninit", 256'(proc_ninit), 256'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst digest", digest, IV_EXP);
    check("arst done", 256'(done), 256'd0);
    check("arst busy", 256'(busy), 256'd0);
    check("arst ready", 256'(ready), 256'd1);
    check("arst ninit", 256'(proc_ninit), 256'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      dn += int'(done);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      dn += int'(done);
    end
    check("arst no done", 256'(dn), 256'd0);
    check("arst digest held", digest, IV_EXP);
    send_chunk(abc_blk, 1'b0, 1'b0);
    wait_done(lat, ni, rd);
    check("post-rst ninit", 256'(ni), 256'd63);
    check("post-rst digest", digest, ABC_EXP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
